serial_adder_ctrl: RTL and testbench

- Multi-cycle sequential adder for WIDTH-bit operands.
- Adds two bits per clock by feeding slices of the operands, plus a registered carry, into one `adder2bit` instance.
- Captures the carry chain across cycles and assembles the full sum.
- Sits directly upstream of `adder2bit`: it feeds the adder its operand slices and `cin`, and consumes the adder's `sum`/`cout`. It lets the 2-bit datapath serve wider adds under a start/done handshake.

---
 rtl/serial_adder_pkg.sv | 12 +
 rtl/serial_adder_ctrl_adder2bit.sv | 18 +
 rtl/serial_adder_ctrl.sv | 109 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the serial adder block.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam int SLICE_W = 2;

endpackage

// File: rtl/serial_adder_ctrl_adder2bit.sv
// Two-bit ripple slice: the only arithmetic in the serial adder.
module adder2bit
   import serial_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] A,
   input  logic [SLICE_W-1:0] B,
   input  logic               cin,
   output logic [SLICE_W-1:0] sum,
   output logic               cout
);

   logic [SLICE_W:0] total;

   assign total = {1'b0, A} + {1'b0, B} + {{SLICE_W{1'b0}}, cin};
   assign sum   = total[SLICE_W-1:0];
   assign cout  = total[SLICE_W];

endmodule

// File: rtl/serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder built on one 2-bit slice,
// with a start/done handshake.
module serial_adder_ctrl
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int NSLICE = WIDTH / SLICE_W;
   localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t             state;
   logic [WIDTH-1:0]   sa;
   logic [WIDTH-1:0]   sb;
   logic [WIDTH-1:0]   psum;
   logic [WIDTH-1:0]   psum_nxt;
   logic               carry;
   logic [CW-1:0]      cnt;
   logic [SLICE_W-1:0] asum;
   logic               acout;

   adder2bit u_add (
      .A    (sa[SLICE_W-1:0]),
      .B    (sb[SLICE_W-1:0]),
      .cin  (carry),
      .sum  (asum),
      .cout (acout)
   );

   // New slice enters at the top; after NSLICE shifts it is aligned.
   generate
      if (WIDTH == SLICE_W) begin : g_one
         assign psum_nxt = asum;
      end else begin : g_shift
         assign psum_nxt = {asum, psum[WIDTH-1:SLICE_W]};
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         psum  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         ready <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= b;
                  carry <= cin;
                  cnt   <= '0;
                  psum  <= '0;
                  state <= RUN;
                  ready <= 1'b0;
                  busy  <= 1'b1;
               end
            end
            RUN: begin
               sa    <= sa >> SLICE_W;
               sb    <= sb >> SLICE_W;
               psum  <= psum_nxt;
               carry <= acout;
               cnt   <= cnt + CW'(1);
               if (cnt == LAST) begin
                  sum   <= psum_nxt;
                  cout  <= acout;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b1;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: vector table, corner sequences,
// and an exhaustive 4-bit sweep, all checked through scoreboards.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       ready;
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   logic       start4;
   logic [3:0] a4;
   logic [3:0] b4;
   logic       cin4;
   logic       ready4;
   logic       busy4;
   logic       done4;
   logic [3:0] sum4;
   logic       cout4;

   int n_checks = 0;
   int n_fail   = 0;
   int done8_cnt = 0;
   int done4_cnt = 0;

   logic [8:0] q8[$];
   logic [4:0] q4[$];
   logic [8:0] e8;
   logic [4:0] e4;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [8:0] exp;
   } vec_t;

   vec_t tbl[9];

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   serial_adder_ctrl #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst   (rst),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .ready (ready4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         done8_cnt++;
         if (q8.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done8_unexpected: got sum %0h, expected no done",
                     {cout, sum});
         end else begin
            e8 = q8.pop_front();
            check("result8", {23'd0, cout, sum}, {23'd0, e8});
         end
      end
   end

   always @(negedge clk) begin
      if (done4 === 1'b1) begin
         done4_cnt++;
         if (q4.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done4_unexpected: got sum %0h, expected no done",
                     {cout4, sum4});
         end else begin
            e4 = q4.pop_front();
            check("result4", {27'd0, cout4, sum4}, {27'd0, e4});
         end
      end
   end

   task automatic check_reset_outs(input string tag);
      check({tag, "_ready"}, {31'd0, ready}, 32'd1);
      check({tag, "_busy"},  {31'd0, busy},  32'd0);
      check({tag, "_done"},  {31'd0, done},  32'd0);
      check({tag, "_sum"},   {24'd0, sum},   32'd0);
      check({tag, "_cout"},  {31'd0, cout},  32'd0);
   endtask

   task automatic do_add(input logic [7:0] va,
                         input logic [7:0] vb,
                         input logic       vc,
                         input logic [8:0] exp);
      int k;
      int nb;
      k = 0;
      while (ready !== 1'b1 && k < 20) begin
         @(negedge clk);
         k++;
      end
      a = va;
      b = vb;
      cin = vc;
      start = 1'b1;
      q8.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      a = 8'($urandom);
      b = 8'($urandom);
      cin = 1'($urandom);
      check("busy_after_accept", {31'd0, busy}, 32'd1);
      k = 0;
      nb = 0;
      while (done !== 1'b1 && k < 20) begin
         if (busy === 1'b1) nb++;
         @(negedge clk);
         k++;
      end
      check("latency", k, 32'd4);
      check("busy_cycles", nb, 32'd4);
      @(negedge clk);
      check("ready_back", {31'd0, ready}, 32'd1);
      check("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ba[4];
      logic [7:0] bb[4];
      logic [8:0] bexp[4];
      logic [8:0] held;
      int base;
      int issued;
      int last_done;
      int didx;
      int idx;
      int k;

      tbl[0] = '{8'h5A, 8'h3C, 1'b0, 9'h096};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
      tbl[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
      tbl[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
      tbl[4] = '{8'h00, 8'h00, 1'b1, 9'h001};
      tbl[5] = '{8'h80, 8'h80, 1'b0, 9'h100};
      tbl[6] = '{8'h12, 8'h34, 1'b1, 9'h047};
      tbl[7] = '{8'hAA, 8'h55, 1'b1, 9'h100};
      tbl[8] = '{8'h7F, 8'h01, 1'b0, 9'h080};

      ba   = '{8'h01, 8'hF0, 8'hC8, 8'h33};
      bb   = '{8'h02, 8'h0F, 8'h64, 8'h44};
      bexp = '{9'h003, 9'h0FF, 9'h12C, 9'h077};

      rst = 1'b1;
      start = 1'b1;
      a = 8'hA5;
      b = 8'h3C;
      cin = 1'b1;
      start4 = 1'b1;
      a4 = 4'h9;
      b4 = 4'h6;
      cin4 = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outs("reset");
      check("reset_ready4", {31'd0, ready4}, 32'd1);
      rst = 1'b0;
      start = 1'b0;
      start4 = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 9; i++)
         do_add(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].exp);

      // Start during RUN must be ignored.
      base = done8_cnt;
      a = 8'h10;
      b = 8'h20;
      cin = 1'b0;
      start = 1'b1;
      q8.push_back(9'h030);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      check("isolation_dones", done8_cnt - base, 32'd1);
      check("isolation_drained", q8.size(), 32'd0);

      // Async reset in the middle of RUN discards the add.
      a = 8'h77;
      b = 8'h11;
      start = 1'b1;
      q8.push_back(9'h088);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outs("midrun_reset");
      q8.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_add(8'h01, 8'h01, 1'b0, 9'h002);

      // Back-to-back with start held high.
      base = done8_cnt;
      issued = 0;
      last_done = -1;
      didx = 0;
      held = 9'h002;
      start = 1'b1;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done === 1'b1) begin
            if (last_done >= 0)
               check("b2b_spacing", cyc - last_done, 32'd6);
            last_done = cyc;
            if (didx < 4) held = bexp[didx];
            didx++;
         end else begin
            check("b2b_hold", {23'd0, cout, sum}, {23'd0, held});
         end
         if (ready === 1'b1 && issued < 4) begin
            a = ba[issued];
            b = bb[issued];
            cin = 1'b0;
            q8.push_back(bexp[issued]);
            issued++;
         end else if (issued == 4) begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_count", done8_cnt - base, 32'd4);
      check("b2b_drained", q8.size(), 32'd0);

      // Exhaustive sweep on the 4-bit instance.
      idx = 0;
      k = 0;
      start4 = 1'b1;
      while ((idx < 512 || q4.size() != 0) && k < 5000) begin
         if (ready4 === 1'b1 && idx < 512) begin
            a4 = idx[3:0];
            b4 = idx[7:4];
            cin4 = idx[8];
            q4.push_back({1'b0, a4} + {1'b0, b4} + {4'd0, cin4});
            idx++;
         end else if (idx >= 512) begin
            start4 = 1'b0;
         end
         @(negedge clk);
         k++;
      end
      start4 = 1'b0;
      check("exh_drained", q4.size(), 32'd0);
      check("exh_count", done4_cnt, 32'd512);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
